// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load-type bit
// positions inside ld_inst, and the load extension helpers.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 157;
    localparam int MS_TO_WS_BUS_WD = 151;
    localparam int MS_TO_DS_BUS_WD = 53;

    localparam int LD_W  = 0;
    localparam int LD_B  = 1;
    localparam int LD_H  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: selects the addressed byte/halfword from the
// read word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_inst,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte/halfword lane selection and extension by load type.
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = offset[1] ? word[31:16] : word[15:0];

        if (ld_inst[LD_B]) begin
            result = ext8(byte_s, 1'b1);
        end else if (ld_inst[LD_BU]) begin
            result = ext8(byte_s, 1'b0);
        end else if (ld_inst[LD_H]) begin
            result = ext16(half_s, 1'b1);
        end else if (ld_inst[LD_HU]) begin
            result = ext16(half_s, 1'b0);
        end else if (ld_inst[LD_W]) begin
            result = word;
        end else begin
            result = word;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, buffers SRAM load
// data across writeback stalls, aligns loads and forwards results to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ws_allowin,
    output logic                        ms_allowin,
    input  logic                        es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
    input  logic [31:0]                 data_sram_rdata,
    output logic                        ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0]  ms_to_ds_bus,
    output logic                        ms_ex_int,
    input  logic                        ws_ex_int
);

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
    logic [31:0]                rbuf_q, rbuf_d;
    logic                       rbuf_valid_q, rbuf_valid_d;

    logic        ms_ready_go_s;
    logic        csr_ertn_s, sys_exce_s, csr_we_s;
    logic [13:0] csr_num_s;
    logic [31:0] csr_wdata_s, csr_wmask_s;
    logic [4:0]  ld_inst_s;
    logic        res_from_mem_s, gr_we_s;
    logic [4:0]  dest_s;
    logic [31:0] result_s, pc_s;
    logic [31:0] load_word_s, load_res_s, final_result_s;
    logic        leave_s, capture_s;

    assign {csr_ertn_s, sys_exce_s, csr_num_s, csr_we_s, csr_wdata_s, csr_wmask_s,
            ld_inst_s, res_from_mem_s, gr_we_s, dest_s, result_s, pc_s} = bus_q;

    load_align u_load_align (
        .ld_inst (ld_inst_s),
        .offset  (result_s[1:0]),
        .word    (load_word_s),
        .result  (load_res_s)
    );

    // Handshake, flush, load-buffer control and output bus assembly.
    always_comb begin
        ms_ready_go_s  = 1'b1;
        ms_allowin     = !ms_valid_q || (ms_ready_go_s && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go_s && !ws_ex_int;
        leave_s        = ms_to_ws_valid && ws_allowin;
        capture_s      = ms_valid_q && res_from_mem_s && !rbuf_valid_q;

        if (ws_ex_int) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end else begin
            ms_valid_d = ms_valid_q;
        end

        if (es_to_ms_valid && ms_allowin && !ws_ex_int) begin
            bus_d = es_to_ms_bus;
        end else begin
            bus_d = bus_q;
        end

        // Departure or flush beats capture so the next load sees fresh SRAM data.
        if (leave_s || ws_ex_int) begin
            rbuf_valid_d = 1'b0;
            rbuf_d       = rbuf_q;
        end else if (capture_s) begin
            rbuf_valid_d = 1'b1;
            rbuf_d       = data_sram_rdata;
        end else begin
            rbuf_valid_d = rbuf_valid_q;
            rbuf_d       = rbuf_q;
        end

        load_word_s    = rbuf_valid_q ? rbuf_q : data_sram_rdata;
        final_result_s = res_from_mem_s ? load_res_s : result_s;

        ms_to_ws_bus = {csr_ertn_s, sys_exce_s, csr_num_s, csr_we_s, csr_wdata_s,
                        csr_wmask_s, gr_we_s, dest_s, final_result_s, pc_s};
        ms_to_ds_bus = {ms_valid_q && csr_we_s, csr_num_s, ms_valid_q && gr_we_s,
                        dest_s, final_result_s};
        ms_ex_int    = ms_valid_q && (sys_exce_s || csr_ertn_s);
    end

    // Stage state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            rbuf_q       <= 32'h0000_0000;
            rbuf_valid_q <= 1'b0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            bus_q        <= bus_d;
            rbuf_q       <= rbuf_d;
            rbuf_valid_q <= rbuf_valid_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [156:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [150:0] ms_to_ws_bus;
    logic [52:0]  ms_to_ds_bus;
    logic         ms_ex_int;
    logic         ws_ex_int;

    int total = 0;
    int passed = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_ds_bus    (ms_to_ds_bus),
        .ms_ex_int       (ms_ex_int),
        .ws_ex_int       (ws_ex_int)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] LDW  = 5'b00001;
    localparam logic [4:0] LDB  = 5'b00010;
    localparam logic [4:0] LDH  = 5'b00100;
    localparam logic [4:0] LDBU = 5'b01000;
    localparam logic [4:0] LDHU = 5'b10000;

    function automatic logic [156:0] make_bus(
        input logic ertn, input logic exce, input logic [13:0] cnum, input logic cwe,
        input logic [4:0] ld, input logic rfm, input logic gwe, input logic [4:0] dst,
        input logic [31:0] res, input logic [31:0] pc);
        return {ertn, exce, cnum, cwe, 32'hAAAA_5555, 32'hFFFF_0000,
                ld, rfm, gwe, dst, res, pc};
    endfunction

    // Go to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction before an edge; it is accepted at that edge.
    task automatic issue(input logic [156:0] bus);
        es_to_ms_bus   = bus;
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_rdata = 32'h0; ws_ex_int = 1'b0;
        step(); step();
        total++; if (ms_allowin !== 1'b1) $display("FAIL rst_allowin: got %b expected 1", ms_allowin); else passed++;
        total++; if (ms_to_ws_valid !== 1'b0) $display("FAIL rst_ws_valid: got %b expected 0", ms_to_ws_valid); else passed++;
        total++; if (ms_ex_int !== 1'b0) $display("FAIL rst_ex_int: got %b expected 0", ms_ex_int); else passed++;
        total++; if ({ms_to_ds_bus[52], ms_to_ds_bus[37]} !== 2'b00)
            $display("FAIL rst_ds_we: got %b expected 00", {ms_to_ds_bus[52], ms_to_ds_bus[37]}); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_align();
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDB, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h1C00_0000));
        data_sram_rdata = 32'h80FF_FF12; #1;
        total++; if (ms_to_ws_valid !== 1'b1) $display("FAIL ldb_valid: got %b expected 1", ms_to_ws_valid); else passed++;
        total++; if (ms_to_ws_bus[63:32] !== 32'hFFFF_FF80)
            $display("FAIL ld_b: got %h expected ffffff80", ms_to_ws_bus[63:32]); else passed++;
        es_to_ms_bus = make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDBU, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h1C00_0004);
        es_to_ms_valid = 1'b1; step(); es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h80FF_FF12; #1;
        chk("ld_bu", ms_to_ws_bus[63:32], 32'h0000_0080);
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDHU, 1'b1, 1'b1, 5'd4, 32'h0000_2002, 32'h1C00_0008));
        data_sram_rdata = 32'hBEEF_0000; #1;
        chk("ld_hu", ms_to_ws_bus[63:32], 32'h0000_BEEF);
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDH, 1'b1, 1'b1, 5'd4, 32'h0000_2000, 32'h1C00_000C));
        data_sram_rdata = 32'h1234_8001; #1;
        chk("ld_h", ms_to_ws_bus[63:32], 32'hFFFF_8001);
        chk("ld_pc", ms_to_ws_bus[31:0], 32'h1C00_000C);
        step();
        chk("ld_depart", {31'd0, ms_to_ws_valid}, 32'd0);
    endtask

    task automatic test_stall_hold();
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDW, 1'b1, 1'b1, 5'd7, 32'h0000_3000, 32'h1C00_0010));
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h1234_5678; #1;
        chk("ldw_first", ms_to_ws_bus[63:32], 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            data_sram_rdata = 32'hDEAD_0000 + i; #1;
            chk("ldw_hold", ms_to_ws_bus[63:32], 32'h1234_5678);
            chk("ldw_allowin", {31'd0, ms_allowin}, 32'd0);
        end
        ws_allowin = 1'b1; #1;
        chk("ldw_offer", {31'd0, ms_to_ws_valid}, 32'd1);
        step();
        chk("ldw_gone", {31'd0, ms_to_ws_valid}, 32'd0);
    endtask

    task automatic test_back_to_back();
        es_to_ms_bus = make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDW, 1'b1, 1'b1, 5'd1, 32'h0000_4000, 32'h1C00_0020);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_bus = make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDW, 1'b1, 1'b1, 5'd2, 32'h0000_4004, 32'h1C00_0024);
        data_sram_rdata = 32'h1111_1111; #1;
        chk("b2b_first", ms_to_ws_bus[63:32], 32'h1111_1111);
        step();
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h2222_2222; #1;
        chk("b2b_second", ms_to_ws_bus[63:32], 32'h2222_2222);
        chk("b2b_pc", ms_to_ws_bus[31:0], 32'h1C00_0024);
        step();
        data_sram_rdata = 32'h3333_3333; #1;
        chk("b2b_second_hold", ms_to_ws_bus[63:32], 32'h2222_2222);
        ws_allowin = 1'b1;
        step();
    endtask

    task automatic test_flush();
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDW, 1'b1, 1'b1, 5'd9, 32'h0000_5000, 32'h1C00_0030));
        ws_allowin = 1'b0;
        data_sram_rdata = 32'hAAAA_AAAA;
        step();
        ws_ex_int = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b0, 1'b1, 14'h0, 1'b0, 5'b0, 1'b0, 1'b1, 5'd9, 32'h0, 32'h1C00_0034);
        #1;
        chk("flush_now_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        step();
        ws_ex_int = 1'b0; es_to_ms_valid = 1'b0; #1;
        chk("flush_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("flush_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("flush_ex_int", {31'd0, ms_ex_int}, 32'd0);
        ws_allowin = 1'b1; #1;
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, LDW, 1'b1, 1'b1, 5'd9, 32'h0000_5004, 32'h1C00_0038));
        ws_allowin = 1'b0;
        data_sram_rdata = 32'hBBBB_BBBB; #1;
        chk("flush_rbuf_cleared", ms_to_ws_bus[63:32], 32'hBBBB_BBBB);
        ws_allowin = 1'b1;
        step();
    endtask

    task automatic test_forward_exc();
        issue(make_bus(1'b0, 1'b0, 14'h0, 1'b0, 5'b0, 1'b0, 1'b1, 5'd5, 32'h0000_0042, 32'h1C00_0040));
        chk("fwd_we", {31'd0, ms_to_ds_bus[37]}, 32'd1);
        chk("fwd_dest", {27'd0, ms_to_ds_bus[36:32]}, 32'd5);
        chk("fwd_result", ms_to_ds_bus[31:0], 32'h0000_0042);
        chk("fwd_no_ex", {31'd0, ms_ex_int}, 32'd0);
        issue(make_bus(1'b0, 1'b0, 14'h0180, 1'b1, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0044));
        chk("fwd_csr_gr", {31'd0, ms_to_ds_bus[52]}, 32'd1);
        chk("fwd_csr_num", {18'd0, ms_to_ds_bus[51:38]}, 32'h0180);
        chk("fwd_we_off", {31'd0, ms_to_ds_bus[37]}, 32'd0);
        issue(make_bus(1'b0, 1'b1, 14'h0, 1'b0, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0048));
        chk("exc_sys", {31'd0, ms_ex_int}, 32'd1);
        chk("exc_ws_bus", {30'd0, ms_to_ws_bus[150:149]}, 32'd1);
        issue(make_bus(1'b1, 1'b0, 14'h0, 1'b0, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_004C));
        chk("exc_ertn", {31'd0, ms_ex_int}, 32'd1);
        step();
        chk("exc_gone", {31'd0, ms_ex_int}, 32'd0);
    endtask

    task automatic test_reset_mid();
        issue(make_bus(1'b0, 1'b1, 14'h0, 1'b1, LDW, 1'b1, 1'b1, 5'd6, 32'h0000_6000, 32'h1C00_0050));
        ws_allowin = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        step();
        chk("mid_pre_ex", {31'd0, ms_ex_int}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("mid_rst_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("mid_rst_ex", {31'd0, ms_ex_int}, 32'd0);
        chk("mid_rst_ds", {30'd0, ms_to_ds_bus[52], ms_to_ds_bus[37]}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("mid_post_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        ws_allowin = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_stall_hold();
        test_back_to_back();
        test_flush();
        test_forward_exc();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
